// File: rtl/lc3b_types.sv
// Shared LC-3b types: register index, scoreboard counter width and
// the default limit on register writes in flight.
package lc3b_types;

  typedef logic [2:0] lc3b_reg;
  typedef logic [1:0] sb_cnt_t;

  localparam int MAX_INFLIGHT_DEFAULT = 4;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback handshake between the pipeline and the register scoreboard.
interface reg_scoreboard_if;
  import lc3b_types::*;

  logic       issue_valid;
  logic       issue_regwrite;
  lc3b_reg    issue_dest;
  lc3b_reg    src1;
  lc3b_reg    src2;
  logic       src1_used;
  logic       src2_used;
  logic       wb_valid;
  lc3b_reg    wb_dest;
  logic       clear;
  logic       stall;
  logic [7:0] pending_mask;
  logic [2:0] inflight;
  logic       wb_err;

  modport master (
    output issue_valid, issue_regwrite, issue_dest, src1, src2,
           src1_used, src2_used, wb_valid, wb_dest, clear,
    input  stall, pending_mask, inflight, wb_err
  );

  modport slave (
    input  issue_valid, issue_regwrite, issue_dest, src1, src2,
           src1_used, src2_used, wb_valid, wb_dest, clear,
    output stall, pending_mask, inflight, wb_err
  );

endinterface

// File: rtl/sb_counter.sv
// Per-register pending-write counter; a decrement against an empty
// counter is ignored and flagged on err.
module sb_counter
  import lc3b_types::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    inc,
  input  logic    dec,
  input  logic    clr,
  output sb_cnt_t count,
  output logic    err
);

  logic dec_ok;

  assign dec_ok = dec && (count != '0);
  assign err    = dec && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec_ok) begin
      count <= count + 2'd1;
    end else if (!inc && dec_ok) begin
      count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for the LC-3b decode stage: tracks writes in flight
// per register and holds decode on RAW hazards or a full issue window.
module reg_scoreboard
  import lc3b_types::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  reg_scoreboard_if.slave sb
);

  sb_cnt_t    cnt [8];
  logic [7:0] cnt_err;
  logic [7:0] pending;
  logic [2:0] inflight_q;
  logic       wb_err_q;
  logic       src1_hit;
  logic       src2_hit;
  logic       dest_full;
  logic       window_full;
  logic       wb_hit;
  logic       issue_inc;
  logic       wb_err_d;
  logic       stall_c;

  // R0 is never a producer, so its slot is tied off rather than counted.
  assign cnt[0]     = '0;
  assign cnt_err[0] = 1'b0;
  assign pending[0] = 1'b0;

  for (genvar r = 1; r < 8; r++) begin : g_cnt
    sb_counter u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (issue_inc && (sb.issue_dest == lc3b_reg'(r))),
      .dec   (sb.wb_valid && (sb.wb_dest == lc3b_reg'(r))),
      .clr   (sb.clear),
      .count (cnt[r]),
      .err   (cnt_err[r])
    );
    assign pending[r] = (cnt[r] != '0);
  end

  always_comb begin
    wb_hit    = sb.wb_valid && (cnt[sb.wb_dest] != '0);
    // A source is free if this cycle's writeback retires its last pending write.
    src1_hit  = sb.src1_used && (cnt[sb.src1] != '0) &&
                !(sb.wb_valid && (sb.wb_dest == sb.src1) && (cnt[sb.src1] == 2'd1));
    src2_hit  = sb.src2_used && (cnt[sb.src2] != '0) &&
                !(sb.wb_valid && (sb.wb_dest == sb.src2) && (cnt[sb.src2] == 2'd1));
    dest_full = (cnt[sb.issue_dest] == 2'd3);
    // Only a writeback that really frees a slot can make room in a full window.
    window_full = (inflight_q == 3'(MAX_INFLIGHT)) && !wb_hit;
    stall_c   = sb.issue_valid && (src1_hit || src2_hit || dest_full || window_full);
    issue_inc = sb.issue_valid && !stall_c && sb.issue_regwrite && (sb.issue_dest != '0);
    wb_err_d  = sb.wb_valid && !sb.clear && ((sb.wb_dest == '0) || cnt_err[sb.wb_dest]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      wb_err_q <= wb_err_d;
      if (sb.clear) begin
        inflight_q <= '0;
      end else if (issue_inc && !wb_hit) begin
        inflight_q <= inflight_q + 3'd1;
      end else if (!issue_inc && wb_hit) begin
        inflight_q <= inflight_q - 3'd1;
      end
    end
  end

  assign sb.stall        = stall_c;
  assign sb.pending_mask = pending;
  assign sb.inflight     = inflight_q;
  assign sb.wb_err       = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: expected outputs are queued as each
// step is driven and popped for comparison mid-cycle.
module tb_reg_scoreboard;
  import lc3b_types::*;

  typedef struct {
    string      tag;
    logic       stall;
    logic [7:0] mask;
    logic [2:0] inflight;
    logic       wb_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  reg_scoreboard_if sbi();

  reg_scoreboard #(.MAX_INFLIGHT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sbi)
  );

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL queue_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      cmp({e.tag, ".stall"},    {7'd0, sbi.stall},    {7'd0, e.stall});
      cmp({e.tag, ".mask"},     sbi.pending_mask,     e.mask);
      cmp({e.tag, ".inflight"}, {5'd0, sbi.inflight}, {5'd0, e.inflight});
      cmp({e.tag, ".wb_err"},   {7'd0, sbi.wb_err},   {7'd0, e.wb_err});
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, queue what the outputs must be before the next edge.
  task automatic step(input string tag,
                      input logic v, input logic rw, input lc3b_reg dest,
                      input lc3b_reg s1, input logic u1,
                      input lc3b_reg s2, input logic u2,
                      input logic wv, input lc3b_reg wd, input logic clr,
                      input logic est, input logic [7:0] emask,
                      input logic [2:0] einf, input logic eerr);
    exp_t e;
    sbi.issue_valid    = v;
    sbi.issue_regwrite = rw;
    sbi.issue_dest     = dest;
    sbi.src1           = s1;
    sbi.src1_used      = u1;
    sbi.src2           = s2;
    sbi.src2_used      = u2;
    sbi.wb_valid       = wv;
    sbi.wb_dest        = wd;
    sbi.clear          = clr;
    e.tag = tag; e.stall = est; e.mask = emask; e.inflight = einf; e.wb_err = eerr;
    sb_q.push_back(e);
    observe();
  endtask

  initial begin
    //    tag          v  rw dst s1 u1 s2 u2 wv wd clr | st  mask  inf err
    step("reset",      0, 0, 0,  0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0);
    rst_n = 1'b1;

    // RAW hazard on R3, released by the same-cycle writeback
    step("iss_r3",     1, 1, 3,  0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0);
    step("raw_s1",     1, 1, 4,  3, 1, 0, 0, 0, 0, 0,    1, 8'h08, 1, 0);
    step("raw_s2",     1, 1, 4,  0, 0, 3, 1, 0, 0, 0,    1, 8'h08, 1, 0);
    step("raw_wb",     1, 1, 4,  3, 1, 0, 0, 1, 3, 0,    0, 8'h08, 1, 0);
    step("after_wb",   0, 0, 0,  0, 0, 0, 0, 0, 0, 0,    0, 8'h10, 1, 0);
    step("wb_r4",      0, 0, 0,  0, 0, 0, 0, 1, 4, 0,    0, 8'h10, 1, 0);

    // R0 is never pending
    step("iss_r0",     1, 1, 0,  0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0);
    step("src_r0",     1, 1, 0,  0, 1, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0);

    // Window full at four, relieved by a same-cycle writeback
    step("iss_r1",     1, 1, 1,  0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0);
    step("iss_r2",     1, 1, 2,  0, 0, 0, 0, 0, 0, 0,    0, 8'h02, 1, 0);
    step("iss_r4",     1, 1, 4,  0, 0, 0, 0, 0, 0, 0,    0, 8'h06, 2, 0);
    step("iss_r5",     1, 1, 5,  0, 0, 0, 0, 0, 0, 0,    0, 8'h16, 3, 0);
    step("full",       1, 1, 6,  0, 0, 0, 0, 0, 0, 0,    1, 8'h36, 4, 0);
    step("full_wb",    1, 1, 6,  0, 0, 0, 0, 1, 1, 0,    0, 8'h36, 4, 0);
    step("drain_r2",   0, 0, 0,  0, 0, 0, 0, 1, 2, 0,    0, 8'h74, 4, 0);
    step("drain_r4",   0, 0, 0,  0, 0, 0, 0, 1, 4, 0,    0, 8'h70, 3, 0);
    step("drain_r5",   0, 0, 0,  0, 0, 0, 0, 1, 5, 0,    0, 8'h60, 2, 0);
    step("drain_r6",   0, 0, 0,  0, 0, 0, 0, 1, 6, 0,    0, 8'h40, 1, 0);

    // Writeback with nothing pending: one-cycle error pulse
    step("bad_wb",     0, 0, 0,  0, 0, 0, 0, 1, 2, 0,    0, 8'h00, 0, 0);
    step("err_pulse",  0, 0, 0,  0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 0, 1);
    step("err_gone",   0, 0, 0,  0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0);
    step("wb_r0",      0, 0, 0,  0, 0, 0, 0, 1, 0, 0,    0, 8'h00, 0, 0);
    step("err_r0",     0, 0, 0,  0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 0, 1);

    // Counter saturation on R6
    step("r6_a",       1, 1, 6,  0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0);
    step("r6_b",       1, 1, 6,  0, 0, 0, 0, 0, 0, 0,    0, 8'h40, 1, 0);
    step("r6_c",       1, 1, 6,  0, 0, 0, 0, 0, 0, 0,    0, 8'h40, 2, 0);
    step("r6_sat",     1, 1, 6,  0, 0, 0, 0, 0, 0, 0,    1, 8'h40, 3, 0);
    step("r6_hold",    0, 0, 0,  0, 0, 0, 0, 0, 0, 0,    0, 8'h40, 3, 0);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    step("mid_rst",    1, 1, 1,  6, 1, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0);
    rst_n = 1'b1;

    // Clear overrides issue and writeback, and suppresses the error pulse
    step("pre_clr_a",  1, 1, 1,  0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0);
    step("pre_clr_b",  1, 1, 2,  0, 0, 0, 0, 0, 0, 0,    0, 8'h02, 1, 0);
    step("clr",        1, 1, 3,  0, 0, 0, 0, 1, 5, 1,    0, 8'h06, 2, 0);
    step("post_clr",   0, 0, 0,  0, 0, 0, 0, 0, 0, 0,    0, 8'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
